// File: rtl/yuv2rgb_pkg.sv
// Shared constants and pixel type for the YUV->RGB datapath.
// The coefficients live here so the multiplier stage and the bench use the same values.
package yuv2rgb_pkg;

    // Q8 coefficients: round(1.402*256), round(0.344*256), round(0.714*256), round(1.772*256)
    localparam int FRAC_BITS   = 8;
    localparam int ROUND_CONST = 1 << (FRAC_BITS - 1);

    localparam int COEF_RV = 359;
    localparam int COEF_GU = 88;
    localparam int COEF_GV = 183;
    localparam int COEF_BU = 454;

    // Width of the pre-clamp luma + chroma sums
    localparam int SUM_W = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/yuv2rgb_clamp8.sv
// Saturates a signed 13-bit component sum into the 0..255 range and flags clamping.
module yuv2rgb_clamp8
    import yuv2rgb_pkg::*;
(
    input  logic signed [SUM_W-1:0] din,
    output logic        [7:0]       dout,
    output logic                    sat
);

    localparam logic signed [SUM_W-1:0] MAX_U8 = SUM_W'(255);

    // Negative values floor to 0, values above 255 cap at 255
    always_comb begin
        dout = din[7:0];
        sat  = 1'b0;
        if (din[SUM_W-1]) begin
            dout = 8'd0;
            sat  = 1'b1;
        end else if (din > MAX_U8) begin
            dout = 8'hFF;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/yuv2rgb_sum_clamp.sv
// Two-stage YUV->RGB back end: rounds and sums the chroma products, rescales,
// adds luma, saturates to RGB888 and streams pixels out with valid/ready.
// Also marks the last pixel of each line and counts clamped components.
module yuv2rgb_sum_clamp
    import yuv2rgb_pkg::*;
#(
    parameter int PROD_W     = 18,
    parameter int FRAC_BITS  = yuv2rgb_pkg::FRAC_BITS,
    parameter int LINE_WIDTH = 640,
    parameter int SAT_CNT_W  = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_y,
    input  logic signed [PROD_W-1:0] in_prod_rv,
    input  logic signed [PROD_W-1:0] in_prod_gu,
    input  logic signed [PROD_W-1:0] in_prod_gv,
    input  logic signed [PROD_W-1:0] in_prod_bu,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [23:0]              out_rgb,
    output logic                     out_last,
    input  logic                     sat_clear,
    output logic [SAT_CNT_W-1:0]     sat_count
);

    localparam int ACC_W = PROD_W + 2;
    localparam int CNT_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(LINE_WIDTH - 1);
    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1 << (FRAC_BITS - 1));

    // Pipeline state
    logic                    s1_valid_reg, s2_valid_reg;
    logic [7:0]              s1_y_reg;
    logic signed [ACC_W-1:0] s1_r_reg, s1_g_reg, s1_b_reg;
    rgb888_t                 s2_rgb_reg;
    logic [CNT_W-1:0]        line_cnt_reg, line_cnt_next;
    logic [SAT_CNT_W-1:0]    sat_cnt_reg, sat_cnt_next;

    // Handshake: each stage moves when empty or when the stage after it moves
    logic s1_adv, s2_adv, s2_load, out_xfer;
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign s2_load  = s2_adv && s1_valid_reg;
    assign out_xfer = s2_valid_reg && out_ready;

    // Stage 1 arithmetic: sign-extend into the wider accumulator, then add the rounding term
    logic signed [ACC_W-1:0] r_t_next, g_t_next, b_t_next;
    assign r_t_next = ACC_W'(in_prod_rv) + RND;
    assign g_t_next = ACC_W'(in_prod_gu) + ACC_W'(in_prod_gv) + RND;
    assign b_t_next = ACC_W'(in_prod_bu) + RND;

    // Stage 2 arithmetic: floor rescale, then combine with zero-extended luma
    logic signed [ACC_W-1:0] r_sh, g_sh, b_sh;
    logic signed [SUM_W-1:0] y_ext;
    logic signed [SUM_W-1:0] sum_arr [3];
    logic [7:0]              clamp_arr [3];
    logic [2:0]              sat_vec;
    logic [1:0]              sat_inc;
    rgb888_t                 rgb_next;

    assign r_sh  = s1_r_reg >>> FRAC_BITS;
    assign g_sh  = s1_g_reg >>> FRAC_BITS;
    assign b_sh  = s1_b_reg >>> FRAC_BITS;
    assign y_ext = $signed({{(SUM_W-8){1'b0}}, s1_y_reg});

    // Upper shifted bits are out of range for any legal pixel; only the low SUM_W bits are summed
    logic unused_sh_bits;
    assign unused_sh_bits = ^{r_sh[ACC_W-1:SUM_W], g_sh[ACC_W-1:SUM_W], b_sh[ACC_W-1:SUM_W]};

    // Per-component sums feeding the three clamps (R, G, B order)
    always_comb begin
        sum_arr[0] = y_ext + $signed(r_sh[SUM_W-1:0]);
        sum_arr[1] = y_ext - $signed(g_sh[SUM_W-1:0]);
        sum_arr[2] = y_ext + $signed(b_sh[SUM_W-1:0]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_clamp
            yuv2rgb_clamp8 u_clamp (
                .din  (sum_arr[gi]),
                .dout (clamp_arr[gi]),
                .sat  (sat_vec[gi])
            );
        end
    endgenerate

    assign rgb_next.r = clamp_arr[0];
    assign rgb_next.g = clamp_arr[1];
    assign rgb_next.b = clamp_arr[2];
    assign sat_inc    = {1'b0, sat_vec[0]} + {1'b0, sat_vec[1]} + {1'b0, sat_vec[2]};

    // Stage 1 register: capture rounded terms and luma whenever the stage can move
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_y_reg     <= '0;
            s1_r_reg     <= '0;
            s1_g_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_y_reg <= in_y;
                s1_r_reg <= r_t_next;
                s1_g_reg <= g_t_next;
                s1_b_reg <= b_t_next;
            end
        end
    end

    // Stage 2 register: clamped pixel, held while downstream stalls
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_rgb_reg   <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_rgb_reg <= rgb_next;
            end
        end
    end

    // Next-state for the saturation counter (clear wins) and the line position counter
    logic [SAT_CNT_W:0] sat_sum;
    assign sat_sum = {1'b0, sat_cnt_reg} + (SAT_CNT_W+1)'(sat_inc);

    always_comb begin
        sat_cnt_next = sat_cnt_reg;
        if (sat_clear) begin
            sat_cnt_next = '0;
        end else if (s2_load) begin
            sat_cnt_next = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
        end

        line_cnt_next = line_cnt_reg;
        if (out_xfer) begin
            line_cnt_next = (line_cnt_reg == LAST_IDX) ? '0 : line_cnt_reg + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sat_cnt_reg  <= '0;
            line_cnt_reg <= '0;
        end else begin
            sat_cnt_reg  <= sat_cnt_next;
            line_cnt_reg <= line_cnt_next;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_reg;
    assign out_rgb   = s2_rgb_reg;
    assign out_last  = (line_cnt_reg == LAST_IDX) && s2_valid_reg;
    assign sat_count = sat_cnt_reg;

endmodule

// File: doc/yuv2rgb_sum_clamp.md
Name: yuv2rgb_sum_clamp

Overview:
- Downstream consumer of the yuv2rgb coefficient multipliers (8-bit signed chroma × 10-bit unsigned Q8 coefficient → 18-bit signed product).
- Combines the four chroma products with luma, rounds, rescales, saturates to 8-bit R/G/B and emits packed pixels on a valid/ready stream.
- Two-stage pipeline with full-throughput backpressure.
- Also tracks the end-of-line pixel and keeps a saturation-event counter for debug.

Parameters:
- PROD_W, 18, width of each signed product input
- FRAC_BITS, 8, coefficient fraction bits; shift amount after rounding
- LINE_WIDTH, 640, pixels per line; out_last asserted on pixel LINE_WIDTH-1
- SAT_CNT_W, 16, width of saturation counter

Ports:
- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input pixel terms valid
- in_ready  out  1  stage accepts input this cycle
- in_y  in  8  luma, unsigned
- in_prod_rv  in  PROD_W  signed V×1.402 (Q8) term for R
- in_prod_gu  in  PROD_W  signed U×0.344 (Q8) term for G
- in_prod_gv  in  PROD_W  signed V×0.714 (Q8) term for G
- in_prod_bu  in  PROD_W  signed U×1.772 (Q8) term for B
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_rgb  out  24  {R[23:16], G[15:8], B[7:0]}
- out_last  out  1  last pixel of line, qualified by out_valid
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  SAT_CNT_W  number of clamped components; saturates at all-ones

Behaviour:
- Reset: synchronous on ap_rst_n=0 at a clock edge.
  - Clears both stage valids, the line pixel counter and sat_count.
  - Outputs after reset: out_valid=0, out_rgb=0, out_last=0, sat_count=0, in_ready=1.
  - Reset mid-operation discards in-flight pixels; no partial output.
- Handshake:
  - Transfer occurs when valid&ready are both 1 in the same cycle.
  - Stage k advances when !valid_k || ready_{k+1}, so in_ready = !s1_valid || !s2_valid || out_ready.
  - in_ready must not depend combinationally on in_valid.
  - out_rgb/out_last hold stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input transfer to out_valid with no stall; throughput 1 pixel/cycle.
- Stage 1 (registered), arithmetic in signed, no overflow:
  - r_t = in_prod_rv + 2^(FRAC_BITS-1)
  - g_t = in_prod_gu + in_prod_gv + 2^(FRAC_BITS-1), using a PROD_W+2 bit accumulator
  - b_t = in_prod_bu + 2^(FRAC_BITS-1)
  - Register r_t, g_t, b_t and y.
- Stage 2 (registered):
  - Arithmetic right shift by FRAC_BITS (floor).
  - R = y + (r_t>>>8); G = y − (g_t>>>8); B = y + (b_t>>>8).
  - All sums 13-bit signed; y is zero-extended.
  - Clamp each component: <0 → 0, >255 → 255.
- sat_count:
  - Increments by the number of components clamped (0-3) when a pixel enters stage 2.
  - Saturates at 2^SAT_CNT_W−1.
  - sat_clear takes priority over an increment in the same cycle.
- out_last:
  - Line counter increments on each output transfer and wraps to 0 after LINE_WIDTH-1.
  - out_last = (counter == LINE_WIDTH-1) & out_valid.
  - LINE_WIDTH=1 holds out_last=1 on every pixel.

Decomposition:
- Package yuv2rgb_pkg holds:
  - constants FRAC_BITS and the rounding constant
  - pixel typedef rgb888_t with r, g, b fields
  - the coefficient constants (359, 88, 183, 454) so the multiplier stage and the bench share one source
- One sub-module, yuv2rgb_clamp8: combinational 13-bit signed → 8-bit saturate with a sat flag; instantiated three times in stage 2.

Test Plan:
- Y=128, all products 0 → out_rgb=0x808080, sat_count unchanged, out_valid exactly 2 cycles after accept.
- Y=128, V=127 (rv=45593, gv=23241, gu=bu=0) → R=255 (clamped), G=37, B=128, sat_count+1.
- Y=16, V=−128 (rv=−45952, gv=−23424) → R=0 (clamped), G=107, B=16, sat_count+1.
- Continuous in_valid for LINE_WIDTH+2 pixels with out_ready toggling 1/0 each cycle → no loss or duplication, order preserved, out_last only on pixel 639, then the counter wraps.
- ap_rst_n=0 for one cycle with 2 pixels in flight → out_valid=0 next cycle, sat_count=0, the following pixel has counter index 0.
- sat_count at 0xFFFF plus a clamping pixel → stays 0xFFFF; sat_clear with a simultaneous clamp → 0.
